// File: rtl/mem_arb_pkg.sv
// Shared defaults and the round-robin pointer helper for the memory arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 65536;
    localparam int DEF_NCH    = 2;

    // Pointer value after a grant to channel g: the channel just above g, wrapping at nch.
    function automatic int rr_next(input int g, input int nch);
        return (g + 1 >= nch) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mem_arb_ram.sv
// Single-port-per-direction storage: synchronous write, one-cycle registered read.
module mem_arb_ram #(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 65536
) (
    input  logic          clock,
    input  logic          wen,
    input  logic          ren,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write on wen, registered read on ren; the read port holds its last word otherwise.
    // NOTE: the array has no reset branch, so it maps onto RAM macros and keeps contents across reset.
    always_ff @(posedge clock) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter granting one channel per cycle access to a shared memory.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NCH    = DEF_NCH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        rvalid,
    output logic [DATA_W-1:0]     rdata
);

    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  ptr;
    logic              found;
    int                gsel;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_we;
    logic              in_range;
    logic              ram_wen;
    logic              ram_ren;
    logic [DATA_W-1:0] ram_q;
    logic              oob_q;
    logic [DATA_W-1:0] rdata_hold;

    // Pick the first requester at or above ptr, wrapping; nothing is granted during reset.
    // NOTE: every combinational output gets a default before the search so no latch is inferred,
    // and blocking assignments are used here because later statements read earlier results.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gsel  = 0;
        gnt   = '0;
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (!found && i == idx && req[i]) begin
                        found = 1'b1;
                        gsel  = i;
                    end
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            gnt[i] = found && (gsel == i);
        end
    end

    // Route the winning channel's command to the storage ports, dropping out-of-range accesses.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_we    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (gsel == i) begin
                g_addr  = addr[i*ADDR_W +: ADDR_W];
                g_wdata = wdata[i*DATA_W +: DATA_W];
                g_we    = we[i];
            end
        end
        in_range = {1'b0, g_addr} < DEPTH_L;
        ram_wen  = found && g_we && in_range;
        ram_ren  = found && !g_we && in_range;
    end

    mem_arb_ram #(
        .DW    (DATA_W),
        .AW    (RAM_AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .wen   (ram_wen),
        .ren   (ram_ren),
        .waddr (g_addr[RAM_AW-1:0]),
        .raddr (g_addr[RAM_AW-1:0]),
        .wdata (g_wdata),
        .rdata (ram_q)
    );

    // Advance the pointer past each winner and flag read completions one cycle after the grant.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            rvalid     <= '0;
            oob_q      <= 1'b0;
            rdata_hold <= '0;
        end else begin
            if (found) begin
                ptr <= PTR_W'(rr_next(gsel, NCH));
            end
            rvalid     <= (found && !g_we) ? gnt : '0;
            oob_q      <= !in_range;
            rdata_hold <= rdata;
        end
    end

    // Present fresh read data while rvalid is high (zero for out-of-range), otherwise hold.
    assign rdata = (rvalid != '0) ? (oob_q ? '0 : ram_q) : rdata_hold;

endmodule

// File: tb/tb_mem_arb.sv
// Directed plus randomized check of mem_arb (NCH=4, DEPTH=256) against a behavioural model.
module tb_mem_arb;

    localparam int NCH    = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NCH-1:0]        req   = '0;
    logic [NCH-1:0]        we    = '0;
    logic [NCH*ADDR_W-1:0] addr  = '0;
    logic [NCH*DATA_W-1:0] wdata = '0;
    logic [NCH-1:0]        gnt;
    logic [NCH-1:0]        rvalid;
    logic [DATA_W-1:0]     rdata;

    mem_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NCH    (NCH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    always #5 clock = ~clock;

    // Behavioural model state.
    logic [7:0]  m_mem [DEPTH];
    int          m_ptr     = 0;
    logic [3:0]  e_rvalid  = '0;
    logic [7:0]  e_rdata   = '0;
    int          vectors   = 0;
    int          miscompares = 0;

    // One bus cycle. rst: 0 = normal, 1 = reset high all cycle, 2 = reset rises after the grant is seen.
    task automatic cyc(input logic [3:0] r, input logic [3:0] w, input logic [63:0] a,
                       input logic [31:0] d, input int rst);
        int         g;
        int         ad;
        logic [3:0] e_gnt;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        reset = (rst == 1);
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            if (g < 0 && r[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
        end
        e_gnt = (rst == 1 || g < 0) ? 4'b0 : 4'(1 << g);
        @(negedge clock);
        vectors++;
        assert (gnt === e_gnt) else begin
            miscompares++;
            $error("FAIL gnt: got %b want %b", gnt, e_gnt);
        end
        vectors++;
        assert (rvalid === e_rvalid) else begin
            miscompares++;
            $error("FAIL rvalid: got %b want %b", rvalid, e_rvalid);
        end
        vectors++;
        assert (rdata === e_rdata) else begin
            miscompares++;
            $error("FAIL rdata: got %h want %h", rdata, e_rdata);
        end
        if (rst == 2) reset = 1'b1;
        // Predict the effect of the coming edge.
        if (rst != 0) begin
            m_ptr    = 0;
            e_rvalid = '0;
            e_rdata  = '0;
        end else if (g >= 0) begin
            ad = int'(a[g*ADDR_W +: ADDR_W]);
            if (w[g]) begin
                if (ad < DEPTH) m_mem[ad] = d[g*DATA_W +: DATA_W];
                e_rvalid = '0;
            end else begin
                e_rvalid = 4'(1 << g);
                e_rdata  = (ad < DEPTH) ? m_mem[ad] : 8'h00;
            end
            m_ptr = (g + 1) % NCH;
        end else begin
            e_rvalid = '0;
        end
        @(posedge clock);
        #1;
    endtask

    // Single-channel access helper.
    task automatic one(input int ch, input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                       input int rst);
        logic [63:0] aa;
        logic [31:0] dd;
        logic [3:0]  rr;
        aa = '0;
        dd = '0;
        aa[ch*ADDR_W +: ADDR_W] = a;
        dd[ch*DATA_W +: DATA_W] = d;
        rr = 4'(1 << ch);
        cyc(rr, is_wr ? rr : 4'b0, aa, dd, rst);
    endtask

    task automatic idle();
        cyc(4'b0, 4'b0, 64'b0, 32'b0, 0);
    endtask

    initial begin
        logic [63:0] aa;
        logic [31:0] dd;
        @(posedge clock);
        #1;
        // Reset: no grants, outputs cleared.
        cyc(4'b1111, 4'b0, 64'b0, 32'b0, 1);
        cyc(4'b1111, 4'b0, 64'b0, 32'b0, 1);
        idle();
        // Fill storage so every later read has a known expected value.
        for (int i = 0; i < DEPTH; i++) one(0, 1'b1, 16'(i), 8'($urandom), 0);
        // ch0 writes A5 to 0x10, ch1 reads it back.
        one(0, 1'b1, 16'h0010, 8'hA5, 0);
        one(1, 1'b0, 16'h0010, 8'h00, 0);
        idle();
        // All four requesting from ptr=0: order 0,1,2,3,0,1,2,3.
        cyc(4'b0, 4'b0, 64'b0, 32'b0, 1);
        for (int i = 0; i < 8; i++) cyc(4'b1111, 4'b0, {16'd3, 16'd2, 16'd1, 16'd0}, 32'b0, 0);
        idle();
        // ptr=1 with ch0 and ch1 requesting: ch1 then ch0, back to back.
        cyc(4'b0, 4'b0, 64'b0, 32'b0, 1);
        one(0, 1'b0, 16'h0001, 8'h00, 0);
        cyc(4'b0011, 4'b0, {32'b0, 16'h0007, 16'h0006}, 32'b0, 0);
        cyc(4'b0001, 4'b0, {32'b0, 16'h0007, 16'h0006}, 32'b0, 0);
        idle();
        // Out-of-range write discarded, out-of-range read returns zero, word 0 untouched.
        one(2, 1'b1, 16'h0100, 8'h3C, 0);
        one(3, 1'b0, 16'h0100, 8'h00, 0);
        one(1, 1'b0, 16'h0000, 8'h00, 0);
        one(2, 1'b0, 16'hFFFF, 8'h00, 0);
        idle();
        // Consecutive writes to one address, then read returns the second.
        one(0, 1'b1, 16'h0005, 8'h11, 0);
        one(1, 1'b1, 16'h0005, 8'h22, 0);
        one(2, 1'b0, 16'h0005, 8'h00, 0);
        idle();
        // Read granted, reset on that edge: no rvalid; pre-reset write survives reset.
        one(3, 1'b1, 16'h0020, 8'h5E, 0);
        one(0, 1'b0, 16'h0020, 8'h00, 2);
        one(0, 1'b0, 16'h0020, 8'h00, 0);
        idle();
        // Randomized traffic, with occasional resets and out-of-range addresses.
        for (int n = 0; n < 600; n++) begin
            aa = '0;
            for (int c = 0; c < NCH; c++) aa[c*ADDR_W +: ADDR_W] = 16'($urandom_range(0, 299));
            dd = $urandom;
            cyc(4'($urandom), 4'($urandom), aa, dd, ($urandom_range(0, 59) == 0) ? 1 : 0);
        end
        idle();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
